// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one BLK-bit lookahead group resolved per stage.
// Define CLA_SATURATE_EN to clamp the result to the signed limit on overflow.
module pipelined_cla_addsub #(
    parameter int unsigned N   = 32,
    parameter int unsigned BLK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow,
    output logic         zero
);
    localparam int unsigned L  = N / BLK;
    localparam int unsigned LR = (L > 1) ? L - 1 : 1;

    logic         adv;
    logic [N-1:0] be;
    logic         c0;

    // Entry k holds the token leaving stage k: unconsumed operand groups plus finished sum bits
    logic [N-1:0] a_r  [LR];
    logic [N-1:0] be_r [LR];
    logic [N-1:0] s_r  [LR];
    logic         c_r  [LR];
    logic         v_r  [LR];

    logic [N-1:0] st_a  [L];
    logic [N-1:0] st_be [L];
    logic [N-1:0] st_s  [L];
    logic         st_c  [L];
    logic         st_cm [L];
    logic         st_v  [L];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign be       = sub ? ~b : b;
    assign c0       = sub | cin;

    for (genvar k = 0; k < L; k++) begin : g_stage
        logic [N-1:0]   src_a;
        logic [N-1:0]   src_be;
        logic [N-1:0]   src_s;
        logic           src_c;
        logic [N-1:0]   nxt_s;
        logic [BLK-1:0] p;
        logic [BLK-1:0] g;
        logic [BLK:0]   c;

        if (k == 0) begin : g_head
            assign src_a   = a;
            assign src_be  = be;
            assign src_s   = '0;
            assign src_c   = c0;
            assign st_v[k] = in_valid;
        end else begin : g_tail
            assign src_a   = a_r[k-1];
            assign src_be  = be_r[k-1];
            assign src_s   = s_r[k-1];
            assign src_c   = c_r[k-1];
            assign st_v[k] = v_r[k-1];
        end

        always_comb begin
            p = src_a[k*BLK +: BLK] ^ src_be[k*BLK +: BLK];
            g = src_a[k*BLK +: BLK] & src_be[k*BLK +: BLK];
            c = '0;
            c[0] = src_c;
            for (int unsigned i = 0; i < BLK; i++) begin
                c[i+1] = g[i] | (p[i] & c[i]);
            end
            nxt_s = src_s;
            nxt_s[k*BLK +: BLK] = p ^ c[BLK-1:0];
        end

        assign st_a[k]  = src_a;
        assign st_be[k] = src_be;
        assign st_s[k]  = nxt_s;
        assign st_c[k]  = c[BLK];
        assign st_cm[k] = c[BLK-1];
    end

    logic [N-1:0] res;
    logic         ovf;

    assign ovf = st_c[L-1] ^ st_cm[L-1];

`ifdef CLA_SATURATE_EN
    // Overflow only occurs with equal effective operand signs; clamp toward that sign
    always_comb begin
        res = st_s[L-1];
        if (ovf) begin
            res = {st_a[L-1][N-1], {(N-1){~st_be[L-1][N-1]}}};
        end
    end
`else
    assign res = st_s[L-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < LR; k++) begin
                v_r[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k + 1 < L; k++) begin
                v_r[k]  <= st_v[k];
                a_r[k]  <= st_a[k];
                be_r[k] <= st_be[k];
                s_r[k]  <= st_s[k];
                c_r[k]  <= st_c[k];
            end
            out_valid <= st_v[L-1];
            sum       <= res;
            cout      <= st_c[L-1];
            overflow  <= ovf;
            zero      <= (res == '0);
        end
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub: an N=8/BLK=4 instance and an N=32/BLK=8 instance.
module tb_pipelined_cla_addsub;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       iv8, ir8, ov8v, or8, cin8, sub8, co8, of8, z8;
    logic [7:0] a8, b8, s8;
    logic        iv32, ir32, ov32v, or32, cin32, sub32, co32, of32, z32;
    logic [31:0] a32, b32, s32;

    pipelined_cla_addsub #(.N(8), .BLK(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8v), .out_ready(or8), .sum(s8),
        .cout(co8), .overflow(of8), .zero(z8)
    );

    pipelined_cla_addsub #(.N(32), .BLK(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .out_valid(ov32v), .out_ready(or32), .sum(s32),
        .cout(co32), .overflow(of32), .zero(z32)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic [7:0] sat;
    } vec8_t;

    exp_t  q8[$];
    exp_t  q32[$];
    vec8_t vecs [20];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    tog_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        e.zero = (s == 32'h0);
        return e;
    endfunction

    function automatic exp_t exp_of(input vec8_t v);
        logic [7:0] s;
        s = v.sum;
`ifdef CLA_SATURATE_EN
        if (v.ovf) s = v.sat;
`endif
        return mk({24'h0, s}, v.cout, v.ovf);
    endfunction

    task automatic send8(input vec8_t v);
        bit done;
        done = 1'b0;
        iv8 = 1'b1; a8 = v.a; b8 = v.b; cin8 = v.cin; sub8 = v.sub;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = ir8;
            @(posedge clk);
        end
        n_checks++;
        if (done) q8.push_back(exp_of(v));
        else begin
            n_fail++;
            $display("FAIL accept8_timeout: in_ready stayed 0, expected 1");
        end
        #1 iv8 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic s, input exp_t e, input bit push);
        bit done;
        done = 1'b0;
        iv32 = 1'b1; a32 = a; b32 = b; cin32 = c; sub32 = s;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = ir32;
            @(posedge clk);
        end
        n_checks++;
        if (done) begin
            if (push) q32.push_back(e);
        end else begin
            n_fail++;
            $display("FAIL accept32_timeout: in_ready stayed 0, expected 1");
        end
        #1 iv32 = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) or8 = 1'($urandom_range(0, 1));
        end
    end

    initial begin : mon8
        exp_t        e;
        bit          stall_seen;
        logic [11:0] snap;
        stall_seen = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (rst) stall_seen = 1'b0;
            else begin
                check("in_ready8", {31'h0, ir8}, {31'h0, !ov8v || or8});
                if (stall_seen) check("stall_hold8", {20'h0, ov8v, s8, co8, of8, z8}, {20'h0, snap});
                if (ov8v && or8) begin
                    if (q8.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected8: got sum %h, expected no output", s8);
                    end else begin
                        e = q8.pop_front();
                        check("sum8", {24'h0, s8}, e.sum);
                        check("cout8", {31'h0, co8}, {31'h0, e.cout});
                        check("overflow8", {31'h0, of8}, {31'h0, e.ovf});
                        check("zero8", {31'h0, z8}, {31'h0, e.zero});
                    end
                end
                stall_seen = ov8v && !or8;
                snap = {ov8v, s8, co8, of8, z8};
            end
        end
    end

    initial begin : mon32
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("in_ready32", {31'h0, ir32}, {31'h0, !ov32v || or32});
                if (ov32v && or32) begin
                    if (q32.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected32: got sum %h, expected no output", s32);
                    end else begin
                        e = q32.pop_front();
                        check("sum32", s32, e.sum);
                        check("cout32", {31'h0, co32}, {31'h0, e.cout});
                        check("overflow32", {31'h0, of32}, {31'h0, e.ovf});
                        check("zero32", {31'h0, z32}, {31'h0, e.zero});
                    end
                end
            end
        end
    end

    initial begin
        //        a      b      cin   sub   sum    cout  ovf   sat
        vecs = '{
            '{8'h3A, 8'h25, 1'b1, 1'b0, 8'h60, 1'b0, 1'b0, 8'h00},
            '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00},
            '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00},
            '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8'h7F},
            '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h80},
            '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00},
            '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80},
            '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00},
            '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 8'h00},
            '{8'hC8, 8'h64, 1'b0, 1'b1, 8'h64, 1'b1, 1'b1, 8'h80},
            '{8'h64, 8'hC8, 1'b0, 1'b1, 8'h9C, 1'b0, 1'b1, 8'h7F},
            '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00},
            '{8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00},
            '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 8'h00},
            '{8'hFE, 8'hFE, 1'b1, 1'b0, 8'hFD, 1'b1, 1'b0, 8'h00},
            '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8'h7F},
            '{8'h01, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00},
            '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00},
            '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 8'h7F},
            '{8'h9E, 8'h0D, 1'b0, 1'b0, 8'hAB, 1'b0, 1'b0, 8'h00}
        };
        rst = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; or32 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid8", {31'h0, ov8v}, 32'h0);
        check("reset_sum8", {24'h0, s8}, 32'h0);
        check("reset_flags8", {29'h0, co8, of8, z8}, 32'h0);
        check("reset_in_ready8", {31'h0, ir8}, 32'h1);
        check("reset_out_valid32", {31'h0, ov32v}, 32'h0);
        check("reset_sum32", s32, 32'h0);

        // Latency with out_ready held high: two stages for N=8, BLK=4
        @(posedge clk);
        #1 send8(vecs[0]);
        @(negedge clk);
        check("latency8_stage0", {31'h0, ov8v}, 32'h0);
        @(negedge clk);
        check("latency8_out", {31'h0, ov8v}, 32'h1);

        // Back-to-back stream with random backpressure
        @(posedge clk);
        #1 tog_en = 1'b1;
        for (int i = 1; i < 20; i++) send8(vecs[i]);
        for (int n = 0; n < 300 && q8.size() != 0; n++) @(negedge clk);
        check("drain8_remaining", q8.size(), 32'h0);
        @(posedge clk);
        tog_en = 1'b0;
        #2 or8 = 1'b1;

        // Two tokens in flight on the 4-stage instance, then reset
        @(posedge clk);
        #1 send32(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, mk(32'h3, 1'b0, 1'b0), 1'b0);
        send32(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, mk(32'h30, 1'b0, 1'b0), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid32", {31'h0, ov32v}, 32'h0);
        check("midreset_sum32", s32, 32'h0);
        check("midreset_flags32", {29'h0, co32, of32, z32}, 32'h0);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("midreset_no_output32", {31'h0, ov32v}, 32'h0);
        end

        // Carry ripples through all four groups
        @(posedge clk);
        #1 send32(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0), 1'b1);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("latency32_empty", {31'h0, ov32v}, 32'h0);
        end
        @(negedge clk);
        check("latency32_out", {31'h0, ov32v}, 32'h1);

        @(posedge clk);
`ifdef CLA_SATURATE_EN
        #1 send32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h7FFF_FFFF, 1'b0, 1'b1), 1'b1);
`else
        #1 send32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1), 1'b1);
`endif
        send32(32'h1234_5678, 32'h1234_5679, 1'b1, 1'b1, mk(32'hFFFF_FFFF, 1'b0, 1'b0), 1'b1);
        for (int n = 0; n < 50 && q32.size() != 0; n++) @(negedge clk);
        check("drain32_remaining", q32.size(), 32'h0);

        repeat (3) @(negedge clk);
        check("final_queue8", q8.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
